// File: rtl/store_load_buffer.sv
// store_load_buffer: memory-side responder for execute-stage store/load
// requests. Stores are queued and drained to a req/gnt data bus with byte
// strobes; loads wait for the store queue to empty, issue one bus read and
// return a sign- or zero-extended 32-bit result.
module store_load_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_waddr_i,
    input  logic [31:0]   mem_wdata_i,
    input  logic          mem_re_i,
    input  logic [AW-1:0] mem_raddr_i,
    input  logic [1:0]    byte_sel_i,
    input  logic          un_sign_i,
    output logic          stall_o,
    output logic          ld_valid_o,
    output logic [31:0]   ld_data_o,
    output logic          misalign_o,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [31:0]   bus_wdata_o,
    output logic [3:0]    bus_wstrb_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,
    input  logic [31:0]   bus_rdata_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] SL_NONE = 2'd0;
    localparam logic [1:0] SL_BYTE = 2'd1;
    localparam logic [1:0] SL_HALF = 2'd2;
    localparam logic [1:0] SL_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LD_REQ,
        LD_WAIT
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [3:0]    fifo_strb [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [AW-1:0] ld_addr;
    logic [1:0]    ld_off;
    logic [1:0]    ld_size;
    logic          ld_uns;
    logic [31:0]   ld_data_q;
    logic [31:0]   ld_ext;
    logic          misalign_q;

    logic          st_req, ld_req, misaligned, can_accept, fifo_full;
    logic          enq, deq, ld_start, bad_req;
    logic [1:0]    req_off;
    logic [31:0]   st_data;
    logic [3:0]    st_strb;

    // Request decode: a store wins over a simultaneous load.
    always_comb begin
        st_req     = mem_we_i && (byte_sel_i != SL_NONE);
        ld_req     = mem_re_i && !mem_we_i && (byte_sel_i != SL_NONE);
        req_off    = mem_we_i ? mem_waddr_i[1:0] : mem_raddr_i[1:0];
        misaligned = ((byte_sel_i == SL_HALF) && req_off[0]) ||
                     ((byte_sel_i == SL_WORD) && (req_off != 2'b00));
        can_accept = (state == IDLE) || (state == DRAIN);
        fifo_full  = (count == FULL_COUNT);
        enq        = can_accept && st_req && !misaligned && !fifo_full;
        bad_req    = can_accept && (st_req || ld_req) && misaligned;
    end

    // Store lane replication and strobe generation.
    always_comb begin
        st_data = mem_wdata_i;
        st_strb = 4'b1111;
        case (byte_sel_i)
            SL_BYTE: begin
                st_data = {4{mem_wdata_i[7:0]}};
                st_strb = 4'b0001 << mem_waddr_i[1:0];
            end
            SL_HALF: begin
                st_data = {2{mem_wdata_i[15:0]}};
                st_strb = 4'b0011 << {mem_waddr_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Load result extraction from the latched byte offset, size and signedness.
    always_comb begin
        case (ld_size)
            SL_BYTE: begin
                ld_ext = ld_uns ? {24'h0, bus_rdata_i[{ld_off, 3'b000} +: 8]}
                                : {{24{bus_rdata_i[{ld_off, 3'b111}]}},
                                   bus_rdata_i[{ld_off, 3'b000} +: 8]};
            end
            SL_HALF: begin
                ld_ext = ld_uns ? {16'h0, bus_rdata_i[{ld_off[1], 4'b0000} +: 16]}
                                : {{16{bus_rdata_i[{ld_off[1], 4'b1111}]}},
                                   bus_rdata_i[{ld_off[1], 4'b0000} +: 16]};
            end
            default: ld_ext = bus_rdata_i;
        endcase
        ld_data_o = ld_valid_o ? ld_ext : ld_data_q;
    end

    // Next-state, bus drive and pipeline stall.
    always_comb begin
        state_next  = state;
        deq         = 1'b0;
        ld_start    = 1'b0;
        stall_o     = 1'b0;
        ld_valid_o  = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_wstrb_o = '0;
        case (state)
            IDLE: begin
                stall_o = (st_req && !misaligned && fifo_full) || (ld_req && !misaligned);
                // A store accepted this cycle goes straight to DRAIN so the bus
                // request appears one cycle after acceptance.
                if (enq || (count != '0)) begin
                    state_next = DRAIN;
                end else if (ld_req && !misaligned) begin
                    ld_start   = 1'b1;
                    state_next = LD_REQ;
                end
            end
            DRAIN: begin
                stall_o     = (st_req && !misaligned && fifo_full) || (ld_req && !misaligned);
                bus_req_o   = 1'b1;
                bus_we_o    = 1'b1;
                bus_addr_o  = fifo_addr[rd_ptr];
                bus_wdata_o = fifo_data[rd_ptr];
                bus_wstrb_o = fifo_strb[rd_ptr];
                if (bus_gnt_i) begin
                    deq = 1'b1;
                    if ((count == CW'(1)) && !enq) begin
                        state_next = IDLE;
                    end
                end
            end
            LD_REQ: begin
                stall_o    = 1'b1;
                bus_req_o  = 1'b1;
                bus_addr_o = ld_addr;
                if (bus_gnt_i) begin
                    state_next = LD_WAIT;
                end
            end
            LD_WAIT: begin
                stall_o = !bus_rvalid_i;
                if (bus_rvalid_i) begin
                    ld_valid_o = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, queue pointers, load context and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ld_addr    <= '0;
            ld_off     <= '0;
            ld_size    <= '0;
            ld_uns     <= 1'b0;
            ld_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_next;
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (ld_start) begin
                ld_addr <= {mem_raddr_i[AW-1:2], 2'b00};
                ld_off  <= mem_raddr_i[1:0];
                ld_size <= byte_sel_i;
                ld_uns  <= un_sign_i;
            end
            if (ld_valid_o) begin
                ld_data_q <= ld_ext;
            end
            misalign_q <= bad_req;
        end
    end

    // Queue storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= {mem_waddr_i[AW-1:2], 2'b00};
            fifo_data[wr_ptr] <= st_data;
            fifo_strb[wr_ptr] <= st_strb;
        end
    end

    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_store_load_buffer.sv
// Self-checking bench for store_load_buffer: directed vector table, corner
// sequences, and a randomized run against a byte-level reference memory.
module tb_store_load_buffer;
    localparam logic [1:0] SL_NONE = 2'd0;
    localparam logic [1:0] SL_BYTE = 2'd1;
    localparam logic [1:0] SL_HALF = 2'd2;
    localparam logic [1:0] SL_WORD = 2'd3;

    localparam int K_ST   = 0;
    localparam int K_LD   = 1;
    localparam int K_MIS  = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we, mem_re, un_sign;
    logic [31:0] mem_waddr, mem_wdata, mem_raddr;
    logic [1:0]  byte_sel;
    logic        stall, ld_valid, misalign, bus_req, bus_we;
    logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          kind;
        logic        we;
        logic        re;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        uns;
        logic [31:0] rdata;
        logic [3:0]  strb;
        logic [31:0] bdata;
        logic [31:0] baddr;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[$];

    logic [7:0]  ref_mem [64];
    logic [31:0] bus_mem [16];
    logic [31:0] exp_q[$];
    bit          mis_exp;

    store_load_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .mem_re_i(mem_re), .mem_raddr_i(mem_raddr),
        .byte_sel_i(byte_sel), .un_sign_i(un_sign),
        .stall_o(stall), .ld_valid_o(ld_valid), .ld_data_o(ld_data),
        .misalign_o(misalign),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_wstrb_o(bus_wstrb),
        .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, want);
        end
    endtask

    task automatic clear_in();
        mem_we = 1'b0; mem_re = 1'b0; byte_sel = SL_NONE; un_sign = 1'b0;
        mem_waddr = '0; mem_raddr = '0; mem_wdata = '0;
    endtask

    function automatic int size_bytes(input logic [1:0] s);
        return (s == SL_BYTE) ? 1 : (s == SL_HALF) ? 2 : 4;
    endfunction

    // Reference load: assemble little-endian bytes, then extend arithmetically.
    function automatic logic [31:0] ref_load(input int a, input int n, input logic uns);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[a+i]) << (8*i);
        if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
        return 32'(v);
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        mem_we = v.we; mem_re = v.re; byte_sel = v.sel; un_sign = v.uns;
        mem_waddr = v.addr; mem_raddr = v.addr; mem_wdata = v.wdata;
        #1;
        chk($sformatf("v%0d_stall", idx), stall, (v.kind == K_LD) ? 1 : 0);
        chk($sformatf("v%0d_req0", idx), bus_req, 0);
        @(negedge clk);
        if (v.kind != K_LD) clear_in();
        #1;
        case (v.kind)
            K_ST: begin
                chk($sformatf("v%0d_req", idx), bus_req, 1);
                chk($sformatf("v%0d_we", idx), bus_we, 1);
                chk($sformatf("v%0d_addr", idx), bus_addr, v.baddr);
                chk($sformatf("v%0d_wdata", idx), bus_wdata, v.bdata);
                chk($sformatf("v%0d_wstrb", idx), bus_wstrb, v.strb);
                chk($sformatf("v%0d_mis", idx), misalign, 0);
                bus_gnt = 1'b1;
                @(negedge clk);
                bus_gnt = 1'b0;
                #1;
                chk($sformatf("v%0d_drained", idx), bus_req, 0);
            end
            K_LD: begin
                chk($sformatf("v%0d_rreq", idx), bus_req, 1);
                chk($sformatf("v%0d_rwe", idx), bus_we, 0);
                chk($sformatf("v%0d_raddr", idx), bus_addr, v.baddr);
                chk($sformatf("v%0d_rstrb", idx), bus_wstrb, 0);
                chk($sformatf("v%0d_rstall", idx), stall, 1);
                bus_gnt = 1'b1;
                @(negedge clk);
                bus_gnt = 1'b0;
                #1;
                chk($sformatf("v%0d_wreq", idx), bus_req, 0);
                chk($sformatf("v%0d_wstall", idx), stall, 1);
                chk($sformatf("v%0d_wvalid", idx), ld_valid, 0);
                @(negedge clk);
                bus_rvalid = 1'b1; bus_rdata = v.rdata;
                #1;
                chk($sformatf("v%0d_valid", idx), ld_valid, 1);
                chk($sformatf("v%0d_data", idx), ld_data, v.ld);
                chk($sformatf("v%0d_stall_rel", idx), stall, 0);
                @(negedge clk);
                bus_rvalid = 1'b0; bus_rdata = '0; clear_in();
                #1;
                chk($sformatf("v%0d_valid_end", idx), ld_valid, 0);
                chk($sformatf("v%0d_hold", idx), ld_data, v.ld);
            end
            K_MIS: begin
                chk($sformatf("v%0d_mis", idx), misalign, 1);
                chk($sformatf("v%0d_mreq", idx), bus_req, 0);
                @(negedge clk);
                #1;
                chk($sformatf("v%0d_mis_end", idx), misalign, 0);
                chk($sformatf("v%0d_mreq_end", idx), bus_req, 0);
            end
            default: begin
                chk($sformatf("v%0d_nmis", idx), misalign, 0);
                chk($sformatf("v%0d_nreq", idx), bus_req, 0);
            end
        endcase
    endtask

    task automatic gen_req(output bit active);
        int r = $urandom_range(0, 19);
        logic [1:0] s = 2'($urandom_range(1, 3));
        int n = size_bytes(s);
        int a = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) a = a - (a % n);
        clear_in();
        active = 1'b1;
        if (r < 8) begin
            mem_we = 1'b1; mem_waddr = 32'(a); mem_wdata = $urandom; byte_sel = s;
            un_sign = 1'($urandom_range(0, 1));
        end else if (r < 16) begin
            mem_re = 1'b1; mem_raddr = 32'(a); byte_sel = s;
            un_sign = 1'($urandom_range(0, 1));
        end else if (r == 16) begin
            mem_we = 1'b1; mem_re = 1'b1; mem_waddr = 32'(a);
            mem_raddr = 32'($urandom_range(0, 63)); mem_wdata = $urandom; byte_sel = s;
        end else if (r == 17) begin
            mem_we = 1'b1; mem_waddr = 32'(a); mem_wdata = $urandom; byte_sel = SL_NONE;
        end else begin
            active = 1'b0;
        end
    endtask

    task automatic model_accept();
        int n, a;
        if (byte_sel == SL_NONE || (!mem_we && !mem_re)) return;
        n = size_bytes(byte_sel);
        a = mem_we ? int'(mem_waddr) : int'(mem_raddr);
        if (a % n != 0) begin
            mis_exp = 1'b1;
            return;
        end
        if (mem_we) begin
            for (int i = 0; i < n; i++) ref_mem[a+i] = 8'(mem_wdata >> (8*i));
        end else begin
            exp_q.push_back(ref_load(a, n, un_sign));
        end
    endtask

    initial begin
        int got, pulses, issued, rd_delay;
        bit pending, rd_seen, have_req, done;
        logic [31:0] rd_word;

        vecs.push_back(vec_t'{K_ST, 1, 0, SL_BYTE, 32'h103, 32'hA5, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h100, 0});
        vecs.push_back(vec_t'{K_ST, 1, 0, SL_HALF, 32'h22, 32'h1234BEEF, 0, 0, 4'b1100, 32'hBEEFBEEF, 32'h20, 0});
        vecs.push_back(vec_t'{K_ST, 1, 0, SL_WORD, 32'h40, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h40, 0});
        vecs.push_back(vec_t'{K_ST, 1, 0, SL_BYTE, 32'h0, 32'h12345678, 0, 0, 4'b0001, 32'h78787878, 32'h0, 0});
        vecs.push_back(vec_t'{K_ST, 1, 0, SL_HALF, 32'h10, 32'h0000CAFE, 0, 0, 4'b0011, 32'hCAFECAFE, 32'h10, 0});
        vecs.push_back(vec_t'{K_LD, 0, 1, SL_BYTE, 32'h21, 0, 0, 32'h80818283, 0, 0, 32'h20, 32'hFFFFFF82});
        vecs.push_back(vec_t'{K_LD, 0, 1, SL_HALF, 32'h22, 0, 1, 32'h80818283, 0, 0, 32'h20, 32'h00008081});
        vecs.push_back(vec_t'{K_LD, 0, 1, SL_HALF, 32'h22, 0, 0, 32'h80818283, 0, 0, 32'h20, 32'hFFFF8081});
        vecs.push_back(vec_t'{K_LD, 0, 1, SL_WORD, 32'h24, 0, 0, 32'h80818283, 0, 0, 32'h24, 32'h80818283});
        vecs.push_back(vec_t'{K_LD, 0, 1, SL_BYTE, 32'h13, 0, 1, 32'h7F0000FF, 0, 0, 32'h10, 32'h0000007F});
        vecs.push_back(vec_t'{K_LD, 0, 1, SL_BYTE, 32'h10, 0, 0, 32'h7F0000FF, 0, 0, 32'h10, 32'hFFFFFFFF});
        vecs.push_back(vec_t'{K_LD, 0, 1, SL_BYTE, 32'h12, 0, 1, 32'h00AB0000, 0, 0, 32'h10, 32'h000000AB});
        vecs.push_back(vec_t'{K_MIS, 0, 1, SL_WORD, 32'h6, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{K_MIS, 1, 0, SL_HALF, 32'h9, 32'h1111, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{K_MIS, 1, 0, SL_WORD, 32'h2, 32'h2222, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{K_MIS, 0, 1, SL_HALF, 32'h3, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{K_ST, 1, 1, SL_BYTE, 32'h5, 32'h3C, 0, 0, 4'b0010, 32'h3C3C3C3C, 32'h4, 0});
        vecs.push_back(vec_t'{K_NONE, 1, 0, SL_NONE, 32'h8, 32'h55, 0, 0, 0, 0, 0, 0});

        rst = 1'b1; clear_in(); bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Fill the queue with the bus stalled, then drain in order.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_we = 1'b1; byte_sel = SL_WORD; mem_waddr = 32'(4*k); mem_wdata = 32'h1000 + 32'(k);
            #1;
            chk($sformatf("fill_stall%0d", k), stall, (k == 4) ? 1 : 0);
        end
        chk("fill_head", bus_addr, 0);
        got = 0;
        pending = 1'b1;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (!pending) clear_in();
            bus_gnt = 1'b1;
            #1;
            if (pending && !stall) pending = 1'b0;
            if (bus_req && bus_we) begin
                chk($sformatf("drain_addr%0d", got), bus_addr, 32'(4*got));
                chk($sformatf("drain_data%0d", got), bus_wdata, 32'h1000 + 32'(got));
                got++;
            end
        end
        chk("drain_count", got, 5);
        @(negedge clk);
        bus_gnt = 1'b0; clear_in();
        #1;
        chk("drain_empty", bus_req, 0);

        // Load behind a pending store: read only after the write is granted.
        @(negedge clk);
        mem_we = 1'b1; byte_sel = SL_WORD; mem_waddr = 32'h20; mem_wdata = 32'h80818283;
        #1;
        chk("lb_st_stall", stall, 0);
        @(negedge clk);
        clear_in(); mem_re = 1'b1; byte_sel = SL_BYTE; mem_raddr = 32'h21; un_sign = 1'b0;
        #1;
        chk("lb_stall", stall, 1);
        chk("lb_wr_first", bus_we, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("lb_hold_stall", stall, 1);
            chk("lb_hold_we", bus_we, 1);
        end
        @(negedge clk);
        #1;
        chk("lb_wr_addr", bus_addr, 32'h20);
        bus_gnt = 1'b1;
        rd_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus_gnt = 1'b0;
            #1;
            if (bus_req && !bus_we) begin
                rd_seen = 1'b1;
                chk("lb_rd_addr", bus_addr, 32'h20);
                bus_gnt = 1'b1;
                break;
            end
        end
        chk("lb_rd_seen", rd_seen, 1);
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        chk("lb_wait_valid", ld_valid, 0);
        pulses = 0;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h80818283;
        #1;
        if (ld_valid) pulses++;
        chk("lb_data", ld_data, 32'hFFFFFF82);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_rvalid = 1'b0; bus_rdata = '0; clear_in();
            #1;
            if (ld_valid) pulses++;
        end
        chk("lb_pulses", pulses, 1);

        // Reset while a read is outstanding; the late rvalid must be ignored.
        @(negedge clk);
        mem_re = 1'b1; byte_sel = SL_WORD; mem_raddr = 32'h30; un_sign = 1'b1;
        @(negedge clk);
        #1;
        chk("rw_rreq", bus_req, 1);
        chk("rw_raddr", bus_addr, 32'h30);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; rst = 1'b1; clear_in();
        @(negedge clk);
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        #1;
        chk("rw_valid", ld_valid, 0);
        chk("rw_data", ld_data, 0);
        chk("rw_stall", stall, 0);
        chk("rw_req", bus_req, 0);
        chk("rw_mis", misalign, 0);
        chk("rw_we", bus_we, 0);
        chk("rw_strb", bus_wstrb, 0);
        @(negedge clk);
        bus_rvalid = 1'b0; bus_rdata = '0;
        #1;
        chk("rw_empty", bus_req, 0);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int i = 0; i < 16; i++) bus_mem[i] = '0;
        mis_exp = 1'b0; issued = 0; have_req = 1'b0; rd_delay = -1; rd_word = '0; done = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            bus_gnt = 1'b0;
            if (!have_req) begin
                if (issued < 400) begin
                    gen_req(have_req);
                    issued++;
                end else begin
                    clear_in();
                end
            end
            if (rd_delay > 0) rd_delay--;
            if (rd_delay == 0) begin
                bus_rvalid = 1'b1; bus_rdata = rd_word; rd_delay = -1;
            end else begin
                bus_rvalid = 1'b0; bus_rdata = $urandom;
            end
            #1;
            chk("rnd_misalign", misalign, mis_exp);
            mis_exp = 1'b0;
            if (have_req && !stall) begin
                model_accept();
                have_req = 1'b0;
            end
            if (ld_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rnd_ld_extra: actual %h required no load result", ld_data);
                end else begin
                    chk("rnd_ld_data", ld_data, exp_q.pop_front());
                end
            end
            if (bus_req && $urandom_range(0, 1) == 1) begin
                bus_gnt = 1'b1;
                if (bus_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus_wstrb[b]) bus_mem[bus_addr[5:2]][8*b +: 8] = bus_wdata[8*b +: 8];
                end else begin
                    rd_word = bus_mem[bus_addr[5:2]];
                    rd_delay = $urandom_range(1, 3);
                end
            end
            if (issued >= 400 && !have_req && exp_q.size() == 0 && rd_delay < 0 &&
                !bus_req && !mis_exp) begin
                done = 1'b1;
                break;
            end
        end
        chk("rnd_done", done, 1);
        @(negedge clk);
        clear_in(); bus_gnt = 1'b0; bus_rvalid = 1'b0;
        for (int w = 0; w < 16; w++)
            chk($sformatf("rnd_mem%0d", w), bus_mem[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
